// File: rtl/puf_key_reader.sv
// rtl/puf_key_reader.sv - PUF response sampler with per-bit majority vote and Hamming-distance key match
module puf_key_reader #(
    parameter int WIDTH         = 64,
    parameter int NUM_SAMPLES   = 7,
    parameter int CNT_W         = 4,
    parameter int SETTLE_CYCLES = 16,
    parameter int HD_THRESH     = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [1:0]       control_sel,
    input  logic [WIDTH-1:0] ref_key,
    input  logic [WIDTH-1:0] puf_response,
    output logic             puf_enable,
    output logic [1:0]       puf_control,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] key_out,
    output logic [6:0]       hamming_dist,
    output logic             match
);

    typedef enum logic [2:0] {
        IDLE, SETTLE, SAMPLE, REARM, VOTE, COMPARE, DONE
    } state_t;

    localparam int SET_W = $clog2(SETTLE_CYCLES + 1);

    state_t           state, state_next;
    logic [SET_W-1:0] settle_cnt;
    logic [CNT_W-1:0] sample_idx;
    logic [CNT_W-1:0] vote_cnt [WIDTH];
    logic [WIDTH-1:0] voted_key, voted_next, diff;
    logic [6:0]       hd_next;
    logic             in_flight, settle_last, sample_last;

    assign in_flight   = (state == SETTLE) || (state == SAMPLE) || (state == REARM) ||
                         (state == VOTE)   || (state == COMPARE);
    assign settle_last = (settle_cnt == SET_W'(SETTLE_CYCLES - 1));
    assign sample_last = (sample_idx == CNT_W'(NUM_SAMPLES - 1));

    assign puf_enable = (state == SETTLE) || (state == SAMPLE);
    assign busy       = in_flight;
    assign done       = (state == DONE);

    always_comb begin
        state_next = state;
        if (in_flight && abort) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    if (start) state_next = SETTLE;
                SETTLE:  if (settle_last) state_next = SAMPLE;
                SAMPLE:  state_next = sample_last ? VOTE : REARM;
                REARM:   state_next = SETTLE;
                VOTE:    state_next = COMPARE;
                COMPARE: state_next = DONE;
                DONE:    state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    // strict majority: a bit is 1 only if more than half the samples saw 1
    always_comb begin
        voted_next = '0;
        for (int i = 0; i < WIDTH; i++) begin
            voted_next[i] = (vote_cnt[i] > CNT_W'(NUM_SAMPLES / 2));
        end
    end

    always_comb begin
        diff    = voted_key ^ ref_key;
        hd_next = '0;
        for (int i = 0; i < WIDTH; i++) begin
            hd_next = hd_next + 7'(diff[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            settle_cnt   <= '0;
            sample_idx   <= '0;
            puf_control  <= '0;
            voted_key    <= '0;
            key_out      <= '0;
            hamming_dist <= '0;
            match        <= 1'b0;
            for (int i = 0; i < WIDTH; i++) vote_cnt[i] <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (start) begin
                        puf_control <= control_sel;
                        settle_cnt  <= '0;
                        sample_idx  <= '0;
                        for (int i = 0; i < WIDTH; i++) vote_cnt[i] <= '0;
                    end
                end
                SETTLE: settle_cnt <= settle_cnt + SET_W'(1);
                SAMPLE: begin
                    sample_idx <= sample_idx + CNT_W'(1);
                    for (int i = 0; i < WIDTH; i++) begin
                        vote_cnt[i] <= vote_cnt[i] + CNT_W'(puf_response[i]);
                    end
                end
                REARM: settle_cnt <= '0;
                VOTE:  voted_key  <= voted_next;
                COMPARE: begin
                    // an abort landing on COMPARE must leave previous results intact
                    if (!abort) begin
                        key_out      <= voted_key;
                        hamming_dist <= hd_next;
                        match        <= (hd_next <= 7'(HD_THRESH));
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
